cpu_run_ctrl: RTL

Run/step/breakpoint sequencer for the pipelined CPU on the board. It replaces free-running CPU clocking with a single-cycle clock enable (cpu_en) on the 100 MHz board clock. It debounces the run and step push-buttons, paces execution in RUN mode, counts committed instructions from dbg_commit, and halts on a programmable commit-count breakpoint. It sits between the board buttons and the CPU instance; commit_cnt and state also feed the debug display path.

---
 rtl/cpu_run_ctrl_if.sv | 33 +++
 rtl/cpu_run_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: board/CPU-facing signal bundle of the run/step/breakpoint sequencer.
//   btn_run, btn_step : raw push-buttons (asynchronous, bouncing)
//   bp_en, bp_count   : breakpoint enable and commit count at which to break
//   dbg_commit        : one-clk pulse per committed instruction from the CPU
//   cpu_en            : CPU clock enable, one clk wide per CPU cycle
//   state             : FSM encoding (0 HALT, 1 RUN, 2 STEP, 3 BREAK)
//   commit_cnt        : committed-instruction count
//   bp_hit            : high while halted on a breakpoint
// master: the board/CPU side that drives buttons and commit strobes.
// slave : the sequencer itself.
interface cpu_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             btn_run;
  logic             btn_step;
  logic             bp_en;
  logic [CNT_W-1:0] bp_count;
  logic             dbg_commit;
  logic             cpu_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] commit_cnt;
  logic             bp_hit;

  modport master (
    output btn_run, btn_step, bp_en, bp_count, dbg_commit,
    input  cpu_en, state, commit_cnt, bp_hit
  );

  modport slave (
    input  btn_run, btn_step, bp_en, bp_count, dbg_commit,
    output cpu_en, state, commit_cnt, bp_hit
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint sequencer for the board CPU.
// Turns debounced run/step buttons into a single-clk CPU clock enable, paces RUN mode to one
// enable every RUN_DIV clocks, counts committed instructions and halts on a commit-count match.
// Ports:
//   clk   : board clock, single domain
//   reset : synchronous, active-high
//   bus   : cpu_run_ctrl_if.slave (buttons, breakpoint config, commit strobe in;
//           cpu_en, state, commit_cnt, bp_hit out)
module cpu_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned RUN_DIV         = 100_000_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic          clk,
  input  logic          reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DivW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(RUN_DIV - 1);

  localparam logic [1:0] StHalt  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StStep  = 2'd2;
  localparam logic [1:0] StBreak = 2'd3;

  // Button index: 0 = run, 1 = step.
  localparam int unsigned BtnRun  = 0;
  localparam int unsigned BtnStep = 1;

  // ---------------------------------------------------------------------------------------------
  // Button synchronise / debounce / press detect
  // ---------------------------------------------------------------------------------------------
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     level_q, level_d;
  logic [1:0]     level_dly_q;
  logic [1:0]     press_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  // The counter only advances while the synced sample disagrees with the accepted level; any
  // sample that agrees again (a bounce back) restarts it, so DEBOUNCE_CYCLES consecutive
  // disagreeing samples are needed before the level flips.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= {bus.btn_step, bus.btn_run};
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      // Registered rising-edge detect: one clk pulse per accepted press.
      press_q     <= level_q & ~level_dly_q;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  logic run_p, step_p;
  assign run_p  = press_q[BtnRun];
  assign step_p = press_q[BtnStep];

  // ---------------------------------------------------------------------------------------------
  // Commit counter and breakpoint match
  // ---------------------------------------------------------------------------------------------
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             bp_evt;

  // Match on the commit that makes the count equal bp_count, so the compare uses count+1
  // (wrapping naturally at CNT_W bits).
  assign cnt_inc      = commit_cnt_q + CNT_W'(1);
  assign bp_evt       = bus.bp_en & bus.dbg_commit & (cnt_inc == bus.bp_count);
  assign commit_cnt_d = bus.dbg_commit ? cnt_inc : commit_cnt_q;

  // ---------------------------------------------------------------------------------------------
  // Run/step FSM
  // ---------------------------------------------------------------------------------------------
  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalt: begin
        if (run_p) begin
          state_d = StRun;
        end else if (step_p) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (bp_evt) begin
          state_d = StBreak;
        end else if (run_p) begin
          state_d = StHalt;
        end
      end
      StStep: begin
        state_d = StHalt;
      end
      StBreak: begin
        if (run_p) begin
          state_d = StRun;
        end else if (step_p) begin
          state_d = StStep;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // RUN pacing
  // ---------------------------------------------------------------------------------------------
  logic [DivW-1:0] rate_q, rate_d;

  // Held at zero unless staying in RUN, so every RUN entry starts a fresh RUN_DIV period.
  always_comb begin
    rate_d = '0;
    if ((state_q == StRun) && (state_d == StRun)) begin
      rate_d = (rate_q == DivLast) ? '0 : rate_q + DivW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StHalt;
      rate_q       <= '0;
      commit_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rate_q       <= rate_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs: decoded from registers only
  // ---------------------------------------------------------------------------------------------
  assign bus.cpu_en     = (state_q == StStep) | ((state_q == StRun) & (rate_q == DivLast));
  assign bus.state      = state_q;
  assign bus.commit_cnt = commit_cnt_q;
  assign bus.bp_hit     = (state_q == StBreak);

endmodule
